// File: rtl/pc_unit_ras.sv
`timescale 1ns/1ps
// Program-counter unit with a return-address stack: picks the next fetch address from
// reset, trap, redirect, stall, RAS prediction or sequential PC+4, one cycle per edge.
module pc_unit_ras #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'(32'h0000_0100),
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic                clk_150_mhz,
    input  logic                pc_rst,
    input  logic                stall,
    input  logic                trap,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                call,
    input  logic                ret,
    output logic [PC_WIDTH-1:0] current_instr,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                misalign,
    output logic                ras_empty,
    output logic                ras_full
);

    localparam int unsigned    PTR_W     = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] COUNT_MAX = (PTR_W+1)'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_top;
    logic [PTR_W-1:0]    ras_top_inc;
    logic [PTR_W:0]      ras_count;
    logic                redirect_misaligned;
    logic                ras_enable;
    logic                do_pop;
    logic                do_push;

    assign pc_plus4  = current_instr + PC_WIDTH'(4);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == COUNT_MAX);

    // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        redirect_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
        ras_enable          = !trap && !redirect_valid && !stall;
        do_pop              = ras_enable && ret && !ras_empty;
        do_push             = ras_enable && call;
        ras_top_inc         = ras_top + PTR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_150_mhz) begin
        if (pc_rst) begin
            current_instr <= RESET_VECTOR;
            misalign      <= 1'b0;
            ras_top       <= '0;
            ras_count     <= '0;
            // NOTE: the small RAS array is reset so a stray read can never return X.
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            misalign <= 1'b0;
            if (trap) begin
                current_instr <= TRAP_VECTOR;
                ras_count     <= '0;
            end else if (redirect_misaligned) begin
                current_instr <= TRAP_VECTOR;
                misalign      <= 1'b1;
            end else if (redirect_valid) begin
                current_instr <= redirect_target;
            end else if (stall) begin
                current_instr <= current_instr;
            end else begin
                current_instr <= do_pop ? ras_mem[ras_top] : pc_plus4;
                if (do_push && do_pop) begin
                    // Pop and push in one cycle: the top slot is simply replaced.
                    ras_mem[ras_top] <= pc_plus4;
                end else if (do_pop) begin
                    ras_top   <= ras_top - PTR_W'(1);
                    ras_count <= ras_count - (PTR_W+1)'(1);
                end else if (do_push) begin
                    ras_mem[ras_top_inc] <= pc_plus4;
                    ras_top              <= ras_top_inc;
                    if (!ras_full) begin
                        ras_count <= ras_count + (PTR_W+1)'(1);
                    end
                end
            end
        end
    end

endmodule
